// File: rtl/boot_ctrl_pkg.sv
// Shared types and constants for the boot controller: state encoding,
// default memory depth, address width and full-word write enable.
package boot_ctrl_pkg;
  localparam int         MEM_WORDS_DEF = 32768;
  localparam int         ADDR_W        = 15;
  localparam logic [3:0] WE_ALL        = 4'hF;

  typedef enum logic [2:0] {
    IDLE, LOAD_I, LOAD_D, RUN, HALT, ERR
  } state_t;
endpackage

// File: rtl/boot_ctrl.sv
// Boot controller: streams an instruction image then a data image into the
// two memories' B ports, releases the CPU from reset, then supervises the run.
module boot_ctrl
  import boot_ctrl_pkg::*;
#(
  parameter int MEM_WORDS = MEM_WORDS_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic [15:0]       imem_words_i,
  input  logic [15:0]       dmem_words_i,
  input  logic [31:0]       timeout_i,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  input  logic [31:0]       s_data_i,
  input  logic              s_last_i,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_din_o,
  output logic              imem_en_o,
  output logic [3:0]        imem_we_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [31:0]       dmem_din_o,
  output logic              dmem_en_o,
  output logic [3:0]        dmem_we_o,
  output logic              cpu_reset_o,
  input  logic              stop_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o,
  output logic [31:0]       cycle_cnt_o
);

  state_t      state;
  logic [15:0] icnt, dcnt, idx;
  logic        run_pend;
  logic        hs, start_ok, bad_cnt, last_i, last_d, final_w;
  logic [31:0] cnt_nxt;

  // run_pend covers the one cycle between the final handshake and RUN so
  // the last memory write lands before the CPU leaves reset.
  assign s_ready_o = (state == LOAD_I || state == LOAD_D) && !run_pend;
  assign hs        = s_valid_i && s_ready_o;
  assign start_ok  = start_i && (state == IDLE || state == HALT || state == ERR);
  assign bad_cnt   = (imem_words_i == 16'd0) ||
                     (int'(imem_words_i) > MEM_WORDS) ||
                     (int'(dmem_words_i) > MEM_WORDS);
  assign last_i    = (idx + 16'd1) == icnt;
  assign last_d    = (idx + 16'd1) == dcnt;
  assign final_w   = (state == LOAD_I) ? (last_i && dcnt == 16'd0) : last_d;
  assign cnt_nxt   = (cycle_cnt_o == 32'hFFFF_FFFF) ? cycle_cnt_o : cycle_cnt_o + 32'd1;

  assign cpu_reset_o = (state != RUN);
  assign busy_o      = (state == LOAD_I) || (state == LOAD_D) || (state == RUN);
  assign done_o      = (state == HALT);
  assign error_o     = (state == ERR);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      icnt        <= '0;
      dcnt        <= '0;
      idx         <= '0;
      run_pend    <= 1'b0;
      cycle_cnt_o <= '0;
      imem_addr_o <= '0;
      imem_din_o  <= '0;
      imem_en_o   <= 1'b0;
      imem_we_o   <= '0;
      dmem_addr_o <= '0;
      dmem_din_o  <= '0;
      dmem_en_o   <= 1'b0;
      dmem_we_o   <= '0;
    end else begin
      imem_en_o <= 1'b0;
      imem_we_o <= '0;
      dmem_en_o <= 1'b0;
      dmem_we_o <= '0;

      // Every accepted word is written, including one that triggers ERR.
      if (hs) begin
        if (state == LOAD_I) begin
          imem_en_o   <= 1'b1;
          imem_we_o   <= WE_ALL;
          imem_addr_o <= idx[ADDR_W-1:0];
          imem_din_o  <= s_data_i;
        end else begin
          dmem_en_o   <= 1'b1;
          dmem_we_o   <= WE_ALL;
          dmem_addr_o <= idx[ADDR_W-1:0];
          dmem_din_o  <= s_data_i;
        end
      end

      if (start_ok) begin
        icnt        <= imem_words_i;
        dcnt        <= dmem_words_i;
        idx         <= '0;
        run_pend    <= 1'b0;
        cycle_cnt_o <= '0;
        state       <= bad_cnt ? ERR : LOAD_I;
      end else begin
        case (state)
          LOAD_I, LOAD_D: begin
            if (run_pend) begin
              run_pend <= 1'b0;
              state    <= RUN;
            end else if (hs) begin
              if (s_last_i != final_w) state <= ERR;
              else if (final_w)        run_pend <= 1'b1;
              else if (state == LOAD_I && last_i) begin
                state <= LOAD_D;
                idx   <= '0;
              end else idx <= idx + 16'd1;
            end
          end
          RUN: begin
            cycle_cnt_o <= cnt_nxt;
            if (stop_i) state <= HALT;
            else if (timeout_i != 32'd0 && cnt_nxt >= timeout_i) state <= ERR;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_boot_ctrl.sv
// Bench for boot_ctrl: directed load/run scenarios, a per-cycle comparison
// against a phase-level model, and literal expectations per scenario.
module tb_boot_ctrl;
  import boot_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start_i = 1'b0;
  logic [15:0] imem_words_i = '0, dmem_words_i = '0;
  logic [31:0] timeout_i = '0;
  logic        s_valid_i = 1'b0, s_last_i = 1'b0;
  logic [31:0] s_data_i = '0;
  logic        stop_i = 1'b0;
  logic        s_ready_o, imem_en_o, dmem_en_o, cpu_reset_o, busy_o, done_o, error_o;
  logic [14:0] imem_addr_o, dmem_addr_o;
  logic [31:0] imem_din_o, dmem_din_o, cycle_cnt_o;
  logic [3:0]  imem_we_o, dmem_we_o;

  always #5 clk = ~clk;

  boot_ctrl dut (
    .clk(clk), .reset(reset), .start_i(start_i),
    .imem_words_i(imem_words_i), .dmem_words_i(dmem_words_i), .timeout_i(timeout_i),
    .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_data_i(s_data_i), .s_last_i(s_last_i),
    .imem_addr_o(imem_addr_o), .imem_din_o(imem_din_o), .imem_en_o(imem_en_o), .imem_we_o(imem_we_o),
    .dmem_addr_o(dmem_addr_o), .dmem_din_o(dmem_din_o), .dmem_en_o(dmem_en_o), .dmem_we_o(dmem_we_o),
    .cpu_reset_o(cpu_reset_o), .stop_i(stop_i), .busy_o(busy_o), .done_o(done_o),
    .error_o(error_o), .cycle_cnt_o(cycle_cnt_o)
  );

  int errors = 0, checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Phase-level model: the two load phases are merged, word position is a
  // single running total across both images.
  localparam int P_IDLE = 0, P_LOAD = 1, P_RUN = 2, P_HALT = 3, P_ERR = 4;
  int          m_ph = P_IDLE, m_ni = 0, m_nd = 0, m_k = 0;
  bit          m_pend = 0, m_fin;
  logic [31:0] m_cnt = '0, m_wdata = '0;
  int          m_wmem = 0, m_waddr = 0;
  int          edge_n = 0, hs_edge = -1, fall_edge = -1;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_ph = P_IDLE; m_pend = 0; m_cnt = '0; m_wmem = 0;
    end else begin
      edge_n++;
      m_wmem = 0;
      if (start_i && m_ph inside {P_IDLE, P_HALT, P_ERR}) begin
        m_ni = int'(imem_words_i); m_nd = int'(dmem_words_i);
        m_k = 0; m_cnt = '0; m_pend = 0;
        m_ph = (m_ni == 0 || m_ni > 32768 || m_nd > 32768) ? P_ERR : P_LOAD;
      end else if (m_ph == P_LOAD && m_pend) begin
        m_ph = P_RUN; m_pend = 0;
      end else if (m_ph == P_LOAD && s_valid_i) begin
        m_fin   = (m_k == m_ni + m_nd - 1);
        m_wmem  = (m_k < m_ni) ? 1 : 2;
        m_waddr = (m_k < m_ni) ? m_k : m_k - m_ni;
        m_wdata = s_data_i;
        hs_edge = edge_n;
        if (s_last_i != m_fin) m_ph = P_ERR;
        else if (m_fin)        m_pend = 1;
        m_k++;
      end else if (m_ph == P_RUN) begin
        if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
        if (stop_i) m_ph = P_HALT;
        else if (timeout_i != 0 && m_cnt >= timeout_i) m_ph = P_ERR;
      end
    end
  end

  int ilog[$], dlog[$];
  int wr_total = 0;
  logic prev_cr = 1'b1;

  always begin
    @(posedge clk); #1;
    check("ctrl", {s_ready_o, busy_o, done_o, error_o, cpu_reset_o},
          {m_ph == P_LOAD && !m_pend, m_ph == P_LOAD || m_ph == P_RUN,
           m_ph == P_HALT, m_ph == P_ERR, m_ph != P_RUN});
    check("cycle_cnt", cycle_cnt_o, m_cnt);
    check("imem_wr", {imem_en_o, imem_we_o}, (m_wmem == 1) ? 5'h1F : 5'h00);
    check("dmem_wr", {dmem_en_o, dmem_we_o}, (m_wmem == 2) ? 5'h1F : 5'h00);
    if (m_wmem == 1) check("imem_addr_din", {imem_addr_o, imem_din_o}, {15'(m_waddr), m_wdata});
    if (m_wmem == 2) check("dmem_addr_din", {dmem_addr_o, dmem_din_o}, {15'(m_waddr), m_wdata});
    if (imem_en_o) begin ilog.push_back(int'(imem_addr_o)); wr_total++; end
    if (dmem_en_o) begin dlog.push_back(int'(dmem_addr_o)); wr_total++; end
    if (prev_cr && !cpu_reset_o) fall_edge = edge_n;
    prev_cr = cpu_reset_o;
  end

  function automatic bit log_ok(input int q[$], input int n);
    if (q.size() != n) return 0;
    foreach (q[i]) if (q[i] != i) return 0;
    return 1;
  endfunction

  task automatic start(input logic [15:0] ni, input logic [15:0] nd);
    start_i = 1'b1; imem_words_i = ni; dmem_words_i = nd;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic send(input int n, input int last_at, input bit rnd, input logic [31:0] base);
    int  i = 0, t = 0;
    bit  hs;
    while (i < n && t < 400) begin
      s_valid_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      s_data_i  = base + 32'(i) * 32'h0101_0101;
      s_last_i  = (i == last_at);
      hs = s_valid_i && s_ready_o;
      @(negedge clk);
      t++;
      if (hs) i++;
    end
    s_valid_i = 1'b0; s_last_i = 1'b0;
    if (i < n) begin errors++; checks++; $display("FAIL send_stall: sent %0d expected %0d", i, n); end
  endtask

  task automatic wait_run();
    int t = 0;
    while (cpu_reset_o && t < 20) begin @(negedge clk); t++; end
    check("run_reached", cpu_reset_o, 1'b0);
  endtask

  task automatic stop_pulse();
    stop_i = 1'b1; @(negedge clk); stop_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    int n_before;
    repeat (3) @(negedge clk);
    check("reset_state", {cpu_reset_o, busy_o, done_o, error_o, s_ready_o, imem_en_o, dmem_en_o, cycle_cnt_o},
          {7'b1000000, 32'd0});
    reset = 1'b1;
    @(negedge clk);

    // Nominal load 4+2, then stop on RUN cycle 100.
    ilog.delete(); dlog.delete();
    start(16'd4, 16'd2);
    send(6, 5, 0, 32'hA000_0000);
    wait_run();
    check("s1_imem_addrs", log_ok(ilog, 4), 1'b1);
    check("s1_dmem_addrs", log_ok(dlog, 2), 1'b1);
    check("s1_run_delay", 64'(fall_edge - hs_edge + 1), 64'd2);
    check("s1_busy", busy_o, 1'b1);
    repeat (99) @(negedge clk);
    stop_pulse();
    check("s4_halt", {done_o, error_o, cpu_reset_o, busy_o}, 4'b1010);
    check("s4_cnt", cycle_cnt_o, 32'd100);
    repeat (3) @(negedge clk);
    check("s4_cnt_held", cycle_cnt_o, 32'd100);

    // Restart from HALT: addresses begin at 0 again.
    ilog.delete(); dlog.delete();
    start(16'd2, 16'd0);
    check("s4_restart_clear", {done_o, cycle_cnt_o}, 33'd0);
    send(2, 1, 0, 32'h5500_0000);
    check("s4_reload_addrs", log_ok(ilog, 2), 1'b1);
    wait_run();
    stop_pulse();

    // Random valid gaps.
    ilog.delete(); dlog.delete();
    start(16'd5, 16'd3);
    send(8, 7, 1, 32'h1234_0000);
    wait_run();
    check("s2_imem_addrs", log_ok(ilog, 5), 1'b1);
    check("s2_dmem_addrs", log_ok(dlog, 3), 1'b1);
    stop_pulse();

    // Early s_last: error, word 2 still written at imem address 1.
    ilog.delete(); dlog.delete();
    start(16'd3, 16'd0);
    send(2, 1, 0, 32'hBEEF_0000);
    check("s3_err", {error_o, cpu_reset_o, busy_o}, 3'b110);
    check("s3_addrs", log_ok(ilog, 2), 1'b1);
    check("s3_din", imem_din_o, 32'hBEEF_0000 + 32'h0101_0101);

    // Missing s_last on the final word.
    ilog.delete(); dlog.delete();
    start(16'd1, 16'd1);
    send(2, -1, 0, 32'h7700_0000);
    check("s3b_err", error_o, 1'b1);
    check("s3b_dmem", {log_ok(ilog, 1), log_ok(dlog, 1)}, 2'b11);

    // Timeout at 50 cycles.
    timeout_i = 32'd50;
    start(16'd1, 16'd0);
    send(1, 0, 0, 32'h0);
    wait_run();
    repeat (60) @(negedge clk);
    check("s5_timeout", {error_o, done_o, cpu_reset_o}, 3'b101);
    check("s5_cnt", cycle_cnt_o, 32'd50);

    // Stop coincident with timeout wins.
    start(16'd1, 16'd0);
    send(1, 0, 0, 32'h0);
    wait_run();
    repeat (49) @(negedge clk);
    stop_pulse();
    check("s5b_stop_prio", {done_o, error_o}, 2'b10);
    check("s5b_cnt", cycle_cnt_o, 32'd50);
    timeout_i = 32'd0;

    // Count bounds.
    start(16'd0, 16'd0);     check("bad_i0", error_o, 1'b1);
    start(16'd32769, 16'd0); check("bad_ibig", error_o, 1'b1);
    start(16'd1, 16'd32769); check("bad_dbig", error_o, 1'b1);
    start(16'd32768, 16'd32768);
    check("max_ok", {busy_o, error_o}, 2'b10);
    reset = 1'b0; @(negedge clk); reset = 1'b1; @(negedge clk);

    // Reset mid-LOAD_D, with an ignored start pulse along the way.
    start(16'd2, 16'd4);
    send(3, -1, 0, 32'hC000_0000);
    start(16'd1, 16'd0);
    check("start_ignored", {busy_o, error_o}, 2'b10);
    send(1, -1, 0, 32'hC100_0000);
    n_before = wr_total;
    s_valid_i = 1'b1;
    #1 reset = 1'b0;
    #1 check("s7_async", {cpu_reset_o, busy_o, s_ready_o, imem_en_o, dmem_en_o}, 5'b10000);
    repeat (3) @(negedge clk);
    check("s7_no_writes", 64'(wr_total - n_before), 64'd0);
    s_valid_i = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("s7_idle", {cpu_reset_o, busy_o, done_o, error_o}, 4'b1000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
